bs_pipe_shift_rotate: RTL and testbench
=======================================

// Module: bs_pipe_shift_rotate
// PURPOSE
//  Parametrised, pipelined barrel shifter: rotate, logical shift or arithmetic
//  shift, left or right, on a WIDTH-bit operand by 0..WIDTH-1 positions.
//  One log2 stage per pipeline register, with a valid/ready handshake on both sides.
//  Feeds the ALU datapath. Replaces the fixed 4-bit combinational rotate unit.
// PARAMETERS
//  WIDTH    8                operand width; power of 2, >= 4
//  SHW      $clog2(WIDTH)    shift-amount width and pipeline depth (derived; do not override)
// PORTS
//  i_clk     in   1      clock; all logic on the rising edge
//  i_rst     in   1      synchronous, active-high reset
//  i_valid   in   1      input operand valid
//  o_ready   out  1      block can accept an input this cycle
//  i_A       in   WIDTH  operand
//  i_k       in   SHW    shift/rotate amount
//  i_left    in   1      1 = left, 0 = right
//  i_mode    in   2      00 rotate, 01 logical shift, 10 arithmetic shift, 11 = logical
//  o_valid   out  1      o_Y valid
//  i_ready   in   1      downstream accepts o_Y
//  o_Y       out  WIDTH  result
// BEHAVIOUR
//  - Reset: all stage valid bits = 0, all stage data = 0, so o_valid=0 and o_Y=0.
//    o_ready=1 in the first cycle after reset deasserts.
//  - Pipeline: SHW registered stages. Stage s applies a shift of 2^s when
//    k[s]=1 and passes data through otherwise. Each stage carries
//    {valid, data, k, left, mode}.
//  - Global stall: adv = !o_valid || i_ready; o_ready = adv (combinational).
//    When adv=1 every stage loads from its predecessor, and stage 0 loads the
//    inputs, with valid0 = i_valid.
//    When adv=0 all stages hold.
//  - Transfers: an input is accepted when i_valid && o_ready. An output is
//    consumed when o_valid && i_ready.
//  - Latency: exactly SHW cycles from acceptance to o_valid when not stalled.
//    Throughput is 1 result per cycle. Order is preserved.
//  - Rotate: bits shifted out re-enter on the opposite end.
//  - Logical: zero fill.
//  - Arithmetic right: fill with the operand MSB, i.e. the sign captured at stage 0
//    and carried through the pipeline.
//  - Arithmetic left: identical to logical left.
//  - k=0: o_Y = i_A in every mode.
//  - Results are defined only for the mode/left/k captured with the operand.
//    Changing the inputs while stalled has no effect unless they are accepted.
//  - o_Y holds its value while o_valid && !i_ready (no change until consumed).
//  - Bubbles (i_valid=0 while adv=1) propagate as valid=0 stages. o_Y content is
//    don't-care when o_valid=0, but it must not be X after reset.
//  - Reset mid-operation: all in-flight results are discarded and never appear
//    on o_valid.
//  - i_ready may toggle freely. There is no combinational path i_valid->o_valid.
// TESTING (WIDTH=8, latency 3)
//  1 Rotate: A=8'b1001_0110, k=3, left=1, mode=00 -> o_Y=8'b1011_0100
//    after 3 cycles; same operand with left=0 -> 8'b1101_0010.
//  2 Shifts: A=8'b1000_0000, k=2, right:
//    mode=10 -> 8'b1110_0000; mode=01 -> 8'b0010_0000;
//    left with A=8'h81, k=1, mode=10 -> 8'h02.
//  3 Stream: 32 back-to-back random ops with i_ready=1 -> 32 results on 32
//    consecutive cycles, in order, matching a reference model;
//    k=0 cases return A unchanged.
//  4 Backpressure: hold i_ready=0 for 5 cycles with the pipe full ->
//    o_ready=0, o_Y/o_valid stable.
//    Release -> no loss or duplication.
//  5 Reset mid-flight: assert i_rst for 1 cycle with 3 ops in flight ->
//    o_valid=0 and o_Y=0 next cycle; none of the 3 results ever emerge.
//  6 Bubbles: valid pattern 1,0,1,1,0 at the input -> the same pattern at the
//    output, delayed 3 cycles.

Source files
------------

// File: rtl/bs_pipe_shift_rotate.sv
// bs_pipe_shift_rotate: pipelined rotate/logical/arithmetic barrel shifter, one log2 stage per register
module bs_pipe_shift_rotate #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [SHW-1:0]   i_k,
  input  logic             i_left,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Y
);
  logic             adv;
  logic             v_q  [SHW];
  logic [WIDTH-1:0] y_q  [SHW];
  logic [WIDTH-1:0] y_d  [SHW];
  logic [SHW-1:0]   k_q  [SHW-1];
  logic             l_q  [SHW-1];
  logic [1:0]       m_q  [SHW-1];
  logic             sg_q [SHW-1];

  // Arithmetic fill uses the sign captured at stage 0, not the partially shifted data.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d, input int n,
                                                   input logic left, input logic [1:0] mode,
                                                   input logic sgn);
    logic [WIDTH-1:0] r;
    logic             fb;
    r = '0;
    fb = !left && mode == 2'b10 && sgn;
    for (int i = 0; i < WIDTH; i++) begin
      if (left) r[i] = (i >= n || mode == 2'b00) ? d[(i - n + WIDTH) % WIDTH] : 1'b0;
      else      r[i] = (i + n < WIDTH || mode == 2'b00) ? d[(i + n) % WIDTH] : fb;
    end
    return r;
  endfunction

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign o_valid = v_q[SHW-1];
  assign o_Y     = y_q[SHW-1];

  always_comb begin
    y_d[0] = i_k[0] ? stage_shift(i_A, 1, i_left, i_mode, i_A[WIDTH-1]) : i_A;
    for (int s = 1; s < SHW; s++)
      y_d[s] = k_q[s-1][s] ? stage_shift(y_q[s-1], 1 << s, l_q[s-1], m_q[s-1], sg_q[s-1]) : y_q[s-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SHW; s++) begin
        v_q[s] <= 1'b0;
        y_q[s] <= '0;
      end
      for (int s = 0; s < SHW - 1; s++) begin
        k_q[s]  <= '0;
        l_q[s]  <= 1'b0;
        m_q[s]  <= 2'b00;
        sg_q[s] <= 1'b0;
      end
    end else if (adv) begin
      v_q[0] <= i_valid;
      y_q[0] <= y_d[0];
      k_q[0]  <= i_k;
      l_q[0]  <= i_left;
      m_q[0]  <= i_mode;
      sg_q[0] <= i_A[WIDTH-1];
      for (int s = 1; s < SHW; s++) begin
        v_q[s] <= v_q[s-1];
        y_q[s] <= y_d[s];
      end
      for (int s = 1; s < SHW - 1; s++) begin
        k_q[s]  <= k_q[s-1];
        l_q[s]  <= l_q[s-1];
        m_q[s]  <= m_q[s-1];
        sg_q[s] <= sg_q[s-1];
      end
    end
  end
endmodule

// File: tb/tb_bs_pipe_shift_rotate.sv
// tb_bs_pipe_shift_rotate: directed and scoreboarded checks of the pipelined barrel shifter
module tb_bs_pipe_shift_rotate;
  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_left, i_ready;
  logic [7:0] i_A;
  logic [2:0] i_k;
  logic [1:0] i_mode;
  logic       o_ready, o_valid;
  logic [7:0] o_Y;
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, n_pop = 0, run = 0, max_run = 0, last_pop = -10;
  logic [7:0] exp_q[$];

  bs_pipe_shift_rotate #(.WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_A(i_A), .i_k(i_k), .i_left(i_left), .i_mode(i_mode),
    .o_valid(o_valid), .i_ready(i_ready), .o_Y(o_Y)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [2:0] k,
                                        input logic l, input logic [1:0] m);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < int'(k); i++) begin
      if (m == 2'b00)     r = l ? {r[6:0], r[7]} : {r[0], r[7:1]};
      else if (l)         r = {r[6:0], 1'b0};
      else if (m == 2'b10) r = {a[7], r[7:1]};
      else                r = {1'b0, r[7:1]};
    end
    return r;
  endfunction

  // Scoreboard: inputs and outputs are stable mid-cycle, so transfers are observed on the falling edge.
  always @(negedge i_clk) begin
    if (i_rst) exp_q.delete();
    else begin
      if (o_valid && i_ready) begin
        check("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sb_data", o_Y, exp_q.pop_front());
        n_pop++;
        run = (last_pop == cyc - 1) ? run + 1 : 1;
        if (run > max_run) max_run = run;
        last_pop = cyc;
      end
      if (i_valid && o_ready) exp_q.push_back(ref_op(i_A, i_k, i_left, i_mode));
    end
    cyc++;
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] a, input logic [2:0] k,
                        input logic l, input logic [1:0] m);
    i_valid = v; i_A = a; i_k = k; i_left = l; i_mode = m;
  endtask

  task automatic op1(input string tag, input logic [7:0] a, input logic [2:0] k,
                     input logic l, input logic [1:0] m, input logic [7:0] e);
    set_in(1'b1, a, k, l, m);
    tick;
    set_in(1'b0, 8'h5a, 3'd7, ~l, ~m);
    check({tag, "_v1"}, o_valid, 0);
    tick;
    check({tag, "_v2"}, o_valid, 0);
    tick;
    check({tag, "_v3"}, o_valid, 1);
    check({tag, "_y"}, o_Y, e);
    tick;
  endtask

  initial begin
    int         p0;
    logic [7:0] y0;
    logic [4:0] pat;
    i_rst = 1'b1; i_ready = 1'b1;
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
    tick; tick;
    i_rst = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_y", o_Y, 0);
    check("rst_ready", o_ready, 1);

    op1("rot_l", 8'b1001_0110, 3'd3, 1'b1, 2'b00, 8'b1011_0100);
    op1("rot_r", 8'b1001_0110, 3'd3, 1'b0, 2'b00, 8'b1101_0010);
    op1("asr", 8'b1000_0000, 3'd2, 1'b0, 2'b10, 8'b1110_0000);
    op1("lsr", 8'b1000_0000, 3'd2, 1'b0, 2'b01, 8'b0010_0000);
    op1("asl", 8'h81, 3'd1, 1'b1, 2'b10, 8'h02);
    op1("mode11", 8'hf0, 3'd4, 1'b0, 2'b11, 8'h0f);
    op1("k0", 8'ha5, 3'd0, 1'b0, 2'b10, 8'ha5);

    p0 = n_pop; max_run = 0;
    for (int i = 0; i < 32; i++) begin
      set_in(1'b1, 8'($urandom), (i % 4 == 0) ? 3'd0 : 3'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      tick;
    end
    i_valid = 1'b0;
    repeat (4) tick;
    check("stream_count", n_pop - p0, 32);
    check("stream_consec", max_run, 32);
    check("stream_drain", exp_q.size(), 0);

    p0 = n_pop;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      tick;
    end
    i_ready = 1'b0;
    set_in(1'b1, 8'h3c, 3'd1, 1'b1, 2'b00);
    y0 = o_Y;
    check("bp_full", o_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      set_in(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      check("bp_ready", o_ready, 0);
      check("bp_valid", o_valid, 1);
      check("bp_y", o_Y, y0);
    end
    i_ready = 1'b1; i_valid = 1'b0;
    repeat (4) tick;
    check("bp_count", n_pop - p0, 3);
    check("bp_drain", exp_q.size(), 0);

    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'hc3 + 8'(i), 3'd2, 1'b0, 2'b01);
      tick;
    end
    i_rst = 1'b1; i_valid = 1'b0;
    tick;
    i_rst = 1'b0; i_ready = 1'b1;
    check("mrst_valid", o_valid, 0);
    check("mrst_y", o_Y, 0);
    check("mrst_ready", o_ready, 1);
    p0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("mrst_quiet", o_valid, 0);
    end
    check("mrst_pops", n_pop - p0, 0);

    pat = 5'b01101;
    for (int j = 0; j < 7; j++) begin
      set_in(j < 5 ? pat[j] : 1'b0, 8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      tick;
      check($sformatf("bub_%0d", j), o_valid, (j >= 2) ? pat[j-2] : 1'b0);
    end
    i_valid = 1'b0;
    repeat (3) tick;
    check("bub_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
